// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Host-facing writer for the TPU instruction memory. Instruction words arrive
// over a valid/ready stream, have their opcode checked and are written in
// order. Every stored program is guaranteed to end with an END/NOP word
// (16'h0000). The loader adds that word itself when the host marks a non-END
// word as last, or when the program runs out of slots. The sequencer reads
// the program through a registered read port. The program is locked while it
// runs and kept afterwards so it can be run again.
//
// Optional feature macro: INSTR_LOADER_PARITY_EN
//   defined   : each word must have even parity over {host_data, host_parity}.
//               A bad word is rejected and sets err_parity. The parity check
//               comes before the opcode check.
//   undefined : host_parity is ignored and err_parity is tied low.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   host_valid     host word valid
//   host_ready     loader can accept a word (EMPTY/LOADING only)
//   host_data      instruction word; opcode = host_data[IW-1:IW-OPW]
//   host_last      final word of the program
//   host_parity    even-parity bit over host_data (optional feature only)
//   clear          discard the stored program (ignored while locked)
//   run_start      sequencer begins executing (accepted in READY)
//   run_done       sequencer finished (accepted in LOCKED)
//   rd_addr        sequencer fetch address
//   rd_data        mem[rd_addr], one cycle after rd_addr
//   prog_ready     a terminated program is stored
//   prog_len       stored word count, including the END word
//   err_opcode     sticky: a word was rejected for an illegal opcode
//   err_overflow   sticky: the program was truncated at DEPTH
//   err_parity     sticky: a word was rejected for a parity error
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int DEPTH  = 8,
  parameter int IW     = 16,
  parameter int OPW    = 3,
  parameter int MAX_OP = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [IW-1:0]            host_data,
  input  logic                     host_last,
  input  logic                     host_parity,
  input  logic                     clear,
  input  logic                     run_start,
  input  logic                     run_done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [IW-1:0]            rd_data,
  output logic                     prog_ready,
  output logic [$clog2(DEPTH):0]   prog_len,
  output logic                     err_opcode,
  output logic                     err_overflow,
  output logic                     err_parity
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_LOADING,
    S_TERM,
    S_READY,
    S_LOCKED
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [LW-1:0]   r_prog_len;
  logic [IW-1:0]   r_mem [DEPTH];
  logic [IW-1:0]   r_rd_data;
  logic            r_err_opcode;
  logic            r_err_overflow;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  state_t          w_state_next;
  logic [AW-1:0]   w_ptr_next;
  logic [LW-1:0]   w_len_next;
  logic            w_mem_we;
  logic [IW-1:0]   w_mem_wdata;
  logic            w_set_err_opcode;
  logic            w_set_err_overflow;
  logic            w_set_err_parity;
  logic            w_clear_errs;

  logic            w_accept;
  logic            w_parity_bad;
  logic            w_opcode_bad;
  logic            w_is_end;
  logic [OPW-1:0]  w_opcode;
  logic [LW-1:0]   w_ptr_plus1;
  logic            w_ptr_at_last;

  assign w_opcode      = host_data[IW-1:IW-OPW];
  assign w_opcode_bad  = (w_opcode > OPW'(MAX_OP));
  assign w_is_end      = (w_opcode == '0);
  assign w_ptr_plus1   = {1'b0, r_wr_ptr} + LW'(1);
  assign w_ptr_at_last = (r_wr_ptr == AW'(DEPTH - 1));

  // host_ready is held low while reset is asserted, even though the state
  // register already reads EMPTY at that point.
  assign host_ready = !reset && ((r_state == S_EMPTY) || (r_state == S_LOADING));
  assign w_accept   = host_valid && host_ready;
  assign prog_ready = (r_state == S_READY) || (r_state == S_LOCKED);

`ifdef INSTR_LOADER_PARITY_EN
  // Even parity: the XOR over the data and its parity bit must be zero.
  assign w_parity_bad = ^{host_data, host_parity};
`else
  assign w_parity_bad = 1'b0;
  // host_parity and the parity-error pulse have no sink in this build.
  logic w_unused_parity;
  assign w_unused_parity = host_parity ^ w_set_err_parity;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state, write control, length and error events
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_ptr_next         = r_wr_ptr;
    w_len_next         = r_prog_len;
    w_mem_we           = 1'b0;
    w_mem_wdata        = host_data;
    w_set_err_opcode   = 1'b0;
    w_set_err_overflow = 1'b0;
    w_set_err_parity   = 1'b0;
    w_clear_errs       = 1'b0;

    case (r_state)
      S_EMPTY, S_LOADING: begin
        if (clear) begin
          // clear takes priority over a word offered on the same beat; any
          // partial program is abandoned.
          w_state_next = S_EMPTY;
          w_ptr_next   = '0;
          w_len_next   = '0;
          w_clear_errs = 1'b1;
        end else if (w_accept) begin
          if (w_parity_bad) begin
            w_set_err_parity = 1'b1;
          end else if (w_opcode_bad) begin
            // Rejected word: nothing written, host_last is ignored.
            w_set_err_opcode = 1'b1;
          end else begin
            w_mem_we     = 1'b1;
            w_ptr_next   = r_wr_ptr + AW'(1);
            w_state_next = S_LOADING;
            if (w_is_end) begin
              w_state_next = S_READY;
              w_len_next   = w_ptr_plus1;
            end else if (w_ptr_at_last) begin
              // Last slot reached without END: store END in its place so
              // the sequencer always finds a terminator.
              w_mem_wdata        = '0;
              w_set_err_overflow = 1'b1;
              w_state_next       = S_READY;
              w_len_next         = LW'(DEPTH);
            end else if (host_last) begin
              w_state_next = S_TERM;
            end
          end
        end
      end

      S_TERM: begin
        if (clear) begin
          w_state_next = S_EMPTY;
          w_ptr_next   = '0;
          w_len_next   = '0;
          w_clear_errs = 1'b1;
        end else begin
          // Append the END word after the host's last word. wr_ptr already
          // points past that word and is at most DEPTH-1 here.
          w_mem_we     = 1'b1;
          w_mem_wdata  = '0;
          w_len_next   = w_ptr_plus1;
          w_state_next = S_READY;
        end
      end

      S_READY: begin
        if (clear) begin
          w_state_next = S_EMPTY;
          w_ptr_next   = '0;
          w_len_next   = '0;
          w_clear_errs = 1'b1;
        end else if (run_start) begin
          w_state_next = S_LOCKED;
        end
      end

      S_LOCKED: begin
        // clear and run_start are ignored; the program stays for re-runs.
        if (run_done) begin
          w_state_next = S_READY;
        end
      end

      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Write pointer and program length
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
    end else begin
      r_wr_ptr   <= w_ptr_next;
      r_prog_len <= w_len_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags: set on the offending beat, cleared by clear.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_opcode   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else if (w_clear_errs) begin
      r_err_opcode   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_set_err_opcode) begin
        r_err_opcode <= 1'b1;
      end
      if (w_set_err_overflow) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_PARITY_EN
  logic r_err_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_parity <= 1'b0;
    end else if (w_clear_errs) begin
      r_err_parity <= 1'b0;
    end else if (w_set_err_parity) begin
      r_err_parity <= 1'b1;
    end
  end

  assign err_parity = r_err_parity;
`else
  assign err_parity = 1'b0;
`endif

  assign err_opcode   = r_err_opcode;
  assign err_overflow = r_err_overflow;
  assign prog_len     = r_prog_len;

  // -------------------------------------------------------------------------
  // Instruction memory. Every slot is cleared on reset, so this is a register
  // array rather than a block RAM. clear does not zero it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[r_wr_ptr] <= w_mem_wdata;
    end
  end

  // Registered read. A write to the same address on the same edge returns
  // the old contents because both use the pre-edge value of r_mem.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int DEPTH = 8;
  localparam int IW    = 16;
  localparam int AW    = 3;

`ifdef INSTR_LOADER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          host_valid;
  logic          host_ready;
  logic [IW-1:0] host_data;
  logic          host_last;
  logic          host_parity;
  logic          clear;
  logic          run_start;
  logic          run_done;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic          prog_ready;
  logic [AW:0]   prog_len;
  logic          err_opcode;
  logic          err_overflow;
  logic          err_parity;

  instr_loader #(.DEPTH(DEPTH), .IW(IW), .OPW(3), .MAX_OP(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_data    (host_data),
    .host_last    (host_last),
    .host_parity  (host_parity),
    .clear        (clear),
    .run_start    (run_start),
    .run_done     (run_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .prog_ready   (prog_ready),
    .prog_len     (prog_len),
    .err_opcode   (err_opcode),
    .err_overflow (err_overflow),
    .err_parity   (err_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, stored word count and sticky flags.
  logic [IW-1:0] m_mem [DEPTH];
  int            m_cnt;
  int            m_len;
  bit            m_eop;
  bit            m_eov;
  bit            m_epar;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_cnt = 0; m_len = 0; m_eop = 0; m_eov = 0; m_epar = 0;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_len = 0; m_eop = 0; m_eov = 0; m_epar = 0;
  endtask

  // Apply one offered word to the program rules. done = program terminated
  // by this word; term = termination needs the extra END-append cycle.
  task automatic model_beat(input logic [IW-1:0] w, input logic l, input logic p,
                            output bit done, output bit term);
    int op;
    done = 0;
    term = 0;
    op   = int'(w[15:13]);
    if (PAR_EN && ((^w) != p)) begin
      m_epar = 1;
      return;
    end
    if (op > 5) begin
      m_eop = 1;
      return;
    end
    if (op == 0) begin
      m_mem[m_cnt] = w; m_cnt++; done = 1;
    end else if (m_cnt == DEPTH - 1) begin
      m_mem[m_cnt] = '0; m_cnt = DEPTH; m_eov = 1; done = 1;
    end else begin
      m_mem[m_cnt] = w; m_cnt++;
      if (l) begin
        m_mem[m_cnt] = '0; m_cnt++; done = 1; term = 1;
      end
    end
    if (done) m_len = m_cnt;
  endtask

  task automatic pulse(input bit c, input bit rs, input bit rd);
    @(negedge clk);
    clear = c; run_start = rs; run_done = rd;
    @(negedge clk);
    clear = 0; run_start = 0; run_done = 0;
  endtask

  task automatic send_beat(input logic [IW-1:0] w, input logic l, input logic p,
                           input bit gap, input string name);
    if (gap) begin
      @(negedge clk);
      host_valid = 0;
    end
    @(negedge clk);
    host_valid = 1; host_data = w; host_last = l; host_parity = p;
    checks++;
    if (host_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s beat host_ready: got %b expected 1 (word %h)", name, host_ready, w);
    end
  endtask

  task automatic check_mem(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      @(negedge clk);
      checks++;
      if (rd_data !== m_mem[a]) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h expected %h", name, a, rd_data, m_mem[a]);
      end
    end
  endtask

  task automatic check_status(input string name, input bit exp_ready);
    logic [AW:0] exp_len;
    exp_len = (AW+1)'(m_len);
    checks++;
    if (prog_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s prog_ready: got %b expected %b", name, prog_ready, exp_ready);
    end
    checks++;
    if (prog_len !== exp_len) begin
      errors++;
      $display("FAIL %s prog_len: got %0d expected %0d", name, prog_len, exp_len);
    end
    checks++;
    if (host_ready !== !exp_ready) begin
      errors++;
      $display("FAIL %s host_ready: got %b expected %b", name, host_ready, !exp_ready);
    end
    checks++;
    if ({err_opcode, err_overflow, err_parity} !== {m_eop, m_eov, m_epar}) begin
      errors++;
      $display("FAIL %s err op/ov/par: got %b%b%b expected %b%b%b", name,
               err_opcode, err_overflow, err_parity, m_eop, m_eov, m_epar);
    end
  endtask

  // Called on the negedge after the terminating beat was offered.
  task automatic finish_program(input bit term, input string name);
    @(negedge clk);
    host_valid = 0; host_last = 0;
    checks++;
    if (prog_ready !== (term ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL %s first-cycle prog_ready: got %b expected %b", name, prog_ready, !term);
    end
    if (term) begin
      @(negedge clk);
      checks++;
      if (prog_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s post-TERM prog_ready: got %b expected 1", name, prog_ready);
      end
    end
    check_status(name, 1'b1);
    check_mem(name);
  endtask

  task automatic stream(input logic [IW-1:0] ws[$], input bit ls[$], input bit ps[$],
                        input string name);
    bit done, term;
    done = 0;
    term = 0;
    for (int i = 0; i < ws.size() && !done; i++) begin
      send_beat(ws[i], ls[i], ps[i], 1'b0, name);
      model_beat(ws[i], ls[i], ps[i], done, term);
    end
    finish_program(term, name);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({host_ready, prog_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset ready: got host=%b prog=%b expected 0 0", host_ready, prog_ready);
    end
    checks++;
    if (prog_len !== '0) begin
      errors++;
      $display("FAIL reset prog_len: got %0d expected 0", prog_len);
    end
    checks++;
    if ({err_opcode, err_overflow, err_parity} !== 3'b000) begin
      errors++;
      $display("FAIL reset errs: got %b%b%b expected 000", err_opcode, err_overflow, err_parity);
    end
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL reset rd_data: got %h expected 0000", rd_data);
    end
    reset = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release host_ready: got %b expected 1", host_ready);
    end
    check_mem("reset");
    $display("test_reset done");
  endtask

  task automatic test_basic_program();
    logic [IW-1:0] ws[$] = '{16'h200F, 16'h4000, 16'h8000, 16'h0000};
    bit ls[$] = '{0, 0, 0, 0};
    bit ps[$];
    foreach (ws[i]) ps.push_back(^ws[i]);
    stream(ws, ls, ps, "basic");
    checks++;
    if (prog_len !== 4'd4) begin
      errors++;
      $display("FAIL basic prog_len: got %0d expected 4", prog_len);
    end
    $display("test_basic_program done");
  endtask

  task automatic test_last_term();
    logic [IW-1:0] ws[$] = '{16'h2001, 16'h4002, 16'h6003};
    bit ls[$] = '{0, 0, 1};
    bit ps[$];
    foreach (ws[i]) ps.push_back(^ws[i]);
    pulse(1, 0, 0); model_clear();
    stream(ws, ls, ps, "last_term");
    $display("test_last_term done");
  endtask

  task automatic test_overflow();
    logic [IW-1:0] ws[$];
    bit ls[$];
    bit ps[$];
    for (int i = 0; i < DEPTH; i++) begin
      ws.push_back(16'h8000 | 16'($urandom_range(16'h1FFF)));
      ls.push_back(0);
      ps.push_back(^ws[i]);
    end
    pulse(1, 0, 0); model_clear();
    stream(ws, ls, ps, "overflow");
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow flag: got %b expected 1", err_overflow);
    end
    $display("test_overflow done");
  endtask

  task automatic test_illegal_opcode();
    logic [IW-1:0] ws[$] = '{16'h200F, 16'hE000, 16'h4000, 16'hC000, 16'h0000};
    bit ls[$] = '{0, 1, 0, 0, 0};
    bit ps[$];
    foreach (ws[i]) ps.push_back(^ws[i]);
    pulse(1, 0, 0); model_clear();
    stream(ws, ls, ps, "illegal");
    $display("test_illegal_opcode done");
  endtask

  task automatic test_lock_run();
    pulse(0, 1, 0);
    @(negedge clk);
    host_valid = 1; host_data = 16'h8000; host_last = 1; host_parity = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (host_ready !== 1'b0) begin
        errors++;
        $display("FAIL locked host_ready: got %b expected 0", host_ready);
      end
      @(negedge clk);
    end
    host_valid = 0; host_last = 0;
    pulse(1, 0, 0);
    check_status("locked_clear", 1'b1);
    pulse(0, 1, 1);
    check_mem("rerun");
    pulse(1, 0, 0); model_clear();
    check_status("after_clear", 1'b0);
    $display("test_lock_run done");
  endtask

  task automatic test_priority();
    logic [IW-1:0] ws[$] = '{16'hA005, 16'h0000};
    bit ls[$] = '{0, 0};
    bit ps[$];
    foreach (ws[i]) ps.push_back(^ws[i]);
    stream(ws, ls, ps, "prio_load");
    pulse(1, 1, 0); model_clear();
    check_status("clear_beats_run", 1'b0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    check_status("run_in_empty", 1'b0);
    stream(ws, ls, ps, "prio_reload");
    $display("test_priority done");
  endtask

  task automatic test_parity();
    logic [IW-1:0] ws[$] = '{16'h200F, 16'hE000, 16'h200F, 16'h0000};
    bit ls[$] = '{0, 0, 0, 0};
    bit ps[$] = '{0, 0, 1, 0};
    pulse(1, 0, 0); model_clear();
    stream(ws, ls, ps, "parity");
    $display("test_parity done");
  endtask

  task automatic test_reset_midrun();
    logic [IW-1:0] ws[$] = '{16'h2001, 16'h0000};
    bit ls[$] = '{0, 0};
    bit ps[$] = '{1, 0};
    bit done, term;
    pulse(1, 0, 0); model_clear();
    stream(ws, ls, ps, "pre_run");
    pulse(0, 1, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if ({prog_ready, host_ready} !== 2'b00) begin
      errors++;
      $display("FAIL midrun reset ready: got prog=%b host=%b expected 0 0", prog_ready, host_ready);
    end
    checks++;
    if ({prog_len, rd_data} !== '0) begin
      errors++;
      $display("FAIL midrun reset len/rd: got %0d/%h expected 0/0000", prog_len, rd_data);
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    send_beat(16'h4001, 0, 1, 1'b0, "midload");
    model_beat(16'h4001, 0, 1, done, term);
    send_beat(16'h6002, 0, 0, 1'b0, "midload");
    model_beat(16'h6002, 0, 0, done, term);
    @(negedge clk);
    host_valid = 0;
    #2 reset = 1;
    #1;
    checks++;
    if ({host_ready, prog_len} !== '0) begin
      errors++;
      $display("FAIL midload reset: got host=%b len=%0d expected 0 0", host_ready, prog_len);
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    check_mem("midload_reset");
    $display("test_reset_midrun done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      bit done, term;
      int beats;
      done = 0; term = 0; beats = 0;
      pulse(1, 0, 0); model_clear();
      while (!done) begin
        logic [IW-1:0] w;
        logic l, p;
        int r;
        r = int'($urandom_range(15));
        w = 16'($urandom_range(16'h1FFF));
        if (beats >= 40)  w = 16'h0000;
        else if (r < 2)   w[15:13] = 3'd0;
        else if (r < 4)   w[15:13] = 3'(6 + (r & 1));
        else              w[15:13] = 3'($urandom_range(5, 1));
        l = ($urandom_range(5) == 0);
        p = ^w;
        if (beats < 40 && $urandom_range(9) == 0) p = ~p;
        send_beat(w, l, p, ($urandom_range(3) == 0), "random");
        model_beat(w, l, p, done, term);
        $display("random it=%0d beat=%0d word=%h last=%b par=%b", it, beats, w, l, p);
        beats++;
      end
      finish_program(term, "random");
      if ($urandom_range(1) == 1) begin
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        check_status("random_rerun", 1'b1);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    reset = 1; host_valid = 0; host_data = '0; host_last = 0; host_parity = 0;
    clear = 0; run_start = 0; run_done = 0; rd_addr = '0;
    model_reset();
    test_reset();
    test_basic_program();
    test_last_term();
    test_overflow();
    test_illegal_opcode();
    test_lock_run();
    test_priority();
    test_parity();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Host-facing writer for the TPU instruction memory. Accepts 16-bit instruction words over a valid/ready stream and checks their opcodes.
- Guarantees every stored program ends with an END/NOP word (16'h0000).
- Exposes a registered read port to the instruction sequencer. Locks the program while the sequencer runs it and keeps it for re-runs.

Parameters:
- DEPTH, 8, number of instruction slots (power of 2, >=2)
- IW, 16, instruction width
- OPW, 3, opcode width (opcode = word[IW-1:IW-OPW])
- MAX_OP, 5, highest legal opcode (000 END/NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 STORE)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- host_valid  in  1  host word valid
- host_ready  out  1  loader can accept a word
- host_data  in  IW  instruction word
- host_last  in  1  final word of the program
- host_parity  in  1  even-parity bit over host_data; used only with the optional feature
- clear  in  1  discard the stored program
- run_start  in  1  sequencer begins executing the program
- run_done  in  1  sequencer reached FINISH
- rd_addr  in  $clog2(DEPTH)  sequencer fetch address
- rd_data  out  IW  instruction at rd_addr, registered
- prog_ready  out  1  a terminated program is stored
- prog_len  out  $clog2(DEPTH)+1  stored word count, including END
- err_opcode  out  1  sticky: word rejected for an illegal opcode
- err_overflow  out  1  sticky: program truncated at DEPTH
- err_parity  out  1  sticky: word rejected for a parity error

Behaviour:
- Reset is asynchronous and active-high on reset; clk is the clock.
- On reset: FSM = EMPTY, wr_ptr = 0, all memory slots = 16'h0000, rd_data = 0, prog_len = 0, all err_* = 0.
- FSM states: EMPTY, LOADING, TERM, READY, LOCKED.
- host_ready = 1 only in EMPTY or LOADING. It is 0 in TERM, READY and LOCKED, and 0 during reset.
- A word is accepted on host_valid && host_ready.
- Illegal opcode (> MAX_OP):
  - Word is not written; wr_ptr unchanged; state unchanged.
  - err_opcode set.
  - host_last on the same beat is ignored.
- Legal word:
  - Written to mem[wr_ptr]; wr_ptr++.
  - EMPTY moves to LOADING.
- Termination, evaluated on each accepted legal word, in priority order:
  1. Word is END (opcode 000) → READY. prog_len = wr_ptr + 1.
  2. wr_ptr == DEPTH-1 and word is not END → 16'h0000 is written instead of the word; err_overflow set; → READY; prog_len = DEPTH.
  3. host_last and word is not END → TERM.
- TERM (one cycle): writes 16'h0000 to mem[wr_ptr]; prog_len = wr_ptr + 1; → READY.
- READY:
  - prog_ready = 1.
  - run_start → LOCKED.
  - clear → EMPTY, wr_ptr = 0, prog_len = 0, prog_ready = 0. Memory is not zeroed.
- LOCKED:
  - prog_ready = 1; host_ready = 0; clear is ignored.
  - run_done → READY; program is retained for re-run.
- If run_start and run_done are both asserted in LOCKED, run_done wins.
- If clear and run_start are both asserted in READY, clear wins.
- clear in EMPTY, LOADING or TERM → EMPTY, wr_ptr = 0, prog_len = 0; any partial program is discarded.
- err_* flags stay set until reset or clear.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, in all states: latency 1 cycle.
  - A same-cycle write to rd_addr returns the old data.
- run_start outside READY is ignored. run_done outside LOCKED is ignored.
- Reset mid-load or mid-run returns the block to the reset state immediately.

Optional Feature:
INSTR_LOADER_PARITY_EN
- Defined:
  - Word is rejected (not written, wr_ptr unchanged) when ^{host_data, host_parity} != 0; err_parity set.
  - Parity is checked before the opcode check. A parity-bad word does not set err_opcode.
- Undefined:
  - host_parity is ignored; err_parity is tied 0.

Test Plan:
- Reset, then stream 001_0000000001111, 010_0…0, 100_0…0, 16'h0000 (one per cycle) → READY after the 4th beat; prog_len = 4; rd_addr = 0 gives rd_data = 16'h200F one cycle later; host_ready = 0.
- Stream 3 words with host_last on the 3rd (a non-END word) → one TERM cycle, mem[3] = 0, prog_len = 4, prog_ready the following cycle.
- Stream 8 COMPUTE words, DEPTH = 8 → mem[7] = 0, err_overflow = 1, prog_len = 8.
- Send 16'hE000 mid-load → not written, err_opcode = 1, next legal word lands at the same address.
- READY → run_start → host_valid is held with host_ready = 0; clear ignored in LOCKED; run_done → READY with memory intact; then clear → EMPTY, err flags cleared.
- With INSTR_LOADER_PARITY_EN: send 16'h200F with host_parity = 0 → rejected, err_parity = 1; resend with host_parity = 1 → accepted.
